// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the fetch->dispatch packet and default sizing.
package fetch_queue_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 8;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] PC;
    } IF_ID_PACKET;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and dispatch: up to 3 in, 3 oldest out,
// per-slot back-pressure from registered occupancy, whole-queue discard on squash.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  IF_ID_PACKET [2:0]          if_packet_in,
    output logic [2:0]                 fq_stall,
    output IF_ID_PACKET [2:0]          fq_packet_out,
    input  logic [1:0]                 dis_consume,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

    // Advance a pointer by 0..3 with explicit wrap so non-power-of-2 depths work.
    function automatic ptr_t ptr_add(input ptr_t ptr, input logic [1:0] n);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + {{(PW-1){1'b0}}, n};
        if (sum >= DEPTH_W) begin
            sum = sum - DEPTH_W;
        end
        return sum[PW-1:0];
    endfunction

    IF_ID_PACKET entries_q [DEPTH];
    IF_ID_PACKET entries_d [DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;

    cnt_t        free;
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    logic [1:0]  n_in;
    logic [1:0]  n_avail;
    logic [1:0]  n_out;

    // Stall depends only on registered occupancy, never on this cycle's dequeue.
    always_comb begin
        free = cnt_t'(DEPTH) - count_q;
        if (free >= cnt_t'(3)) begin
            fq_stall = 3'b000;
        end else if (free == cnt_t'(2)) begin
            fq_stall = 3'b001;
        end else if (free == cnt_t'(1)) begin
            fq_stall = 3'b011;
        end else begin
            fq_stall = 3'b111;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            rd_ptr = ptr_add(head_q, 2'(k));
            if (!squash && (count_q > cnt_t'(k))) begin
                fq_packet_out[2'(2 - k)]       = entries_q[rd_ptr];
                fq_packet_out[2'(2 - k)].valid = 1'b1;
            end else begin
                fq_packet_out[2'(2 - k)] = '0;
            end
        end
        rd_ptr = head_q;
    end

    always_comb begin
        entries_d = entries_q;
        wr_ptr    = tail_q;
        n_in      = 2'd0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (if_packet_in[2'(2 - i)].valid && !fq_stall[2'(2 - i)]) begin
                entries_d[wr_ptr] = if_packet_in[2'(2 - i)];
                wr_ptr            = ptr_add(wr_ptr, 2'd1);
                n_in              = n_in + 2'd1;
            end
        end

        n_avail = (count_q >= cnt_t'(3)) ? 2'd3 : count_q[1:0];
        n_out   = (dis_consume < n_avail) ? dis_consume : n_avail;

        head_d  = ptr_add(head_q, n_out);
        tail_d  = wr_ptr;
        count_d = count_q + cnt_t'(n_in) - cnt_t'(n_out);

        if (squash) begin
            entries_d = entries_q;
            n_out     = 2'd0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    assign fq_count = count_q;

    always_ff @(posedge clock) begin
        entries_q <= entries_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            a_count_max: assert (count_q <= cnt_t'(DEPTH));
            a_no_underflow: assert (cnt_t'(n_out) <= count_q);
            a_consume_clamp: assert (squash || (dis_consume <= n_avail));
        end
    end

endmodule
